// File: rtl/regfile_write_arbiter_if.sv
// Register-file write-port bundle: write-back request, mul/div result handshake,
// the arbitrated write port and the status outputs used by the hazard unit.
interface regfile_write_arbiter_if #(
    parameter int PTR_W = 2
);
    logic             wb_we;
    logic [4:0]       wb_wa;
    logic [31:0]      wb_din;

    // md_* transfers at a posedge where md_valid && md_ready; the producer holds
    // md_wa/md_din stable while md_valid is high and md_ready is low.
    logic             md_valid;
    logic             md_ready;
    logic [4:0]       md_wa;
    logic [31:0]      md_din;

    logic             rf_we;
    logic [4:0]       rf_wa;
    logic [31:0]      rf_din;

    logic [31:0]      pend_mask;
    logic [PTR_W:0]   fifo_count;
    logic [7:0]       squash_cnt;

    modport slave (
        input  wb_we, wb_wa, wb_din, md_valid, md_wa, md_din,
        output md_ready, rf_we, rf_wa, rf_din, pend_mask, fifo_count, squash_cnt
    );

    modport master (
        output wb_we, wb_wa, wb_din, md_valid, md_wa, md_din,
        input  md_ready, rf_we, rf_wa, rf_din, pend_mask, fifo_count, squash_cnt
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between write-back (absolute priority) and
// a small FIFO of mul/div results, squashing queued writes made stale by write-back.
module regfile_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regfile_write_arbiter_if.slave  bus
);
    localparam logic [PTR_W:0] FULL_C = (PTR_W + 1)'(DEPTH);

    logic [4:0]       wa_q  [DEPTH];
    logic [31:0]      din_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [7:0]       sq_q, sq_d;

    logic             wb_act;
    logic             occupied;
    logic             head_vld;
    logic             pop;
    logic             push;
    logic [PTR_W:0]   n_sq;
    logic [8:0]       sq_sum;
    logic [31:0]      pend;

    assign wb_act   = bus.wb_we && (bus.wb_wa != 5'd0);
    assign occupied = (count_q != '0);
    assign head_vld = occupied && vld_q[rd_ptr_q];
    // A squashed head never needs the port, so it leaves even while write-back is busy.
    assign pop      = occupied && (!vld_q[rd_ptr_q] || !wb_act);
    assign bus.md_ready = (count_q < FULL_C);
    assign push     = bus.md_valid && bus.md_ready && (bus.md_wa != 5'd0);

    assign bus.fifo_count = count_q;
    assign bus.squash_cnt = sq_q;
    assign bus.pend_mask  = pend;

    always_comb begin
        bus.rf_we  = 1'b0;
        bus.rf_wa  = 5'd0;
        bus.rf_din = 32'd0;
        if (wb_act) begin
            bus.rf_we  = 1'b1;
            bus.rf_wa  = bus.wb_wa;
            bus.rf_din = bus.wb_din;
        end else if (head_vld) begin
            bus.rf_we  = 1'b1;
            bus.rf_wa  = wa_q[rd_ptr_q];
            bus.rf_din = din_q[rd_ptr_q];
        end
    end

    always_comb begin
        pend = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) pend[wa_q[i]] = 1'b1;
        end
        pend[0] = 1'b0;
    end

    always_comb begin
        vld_d    = vld_q;
        n_sq     = '0;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (wb_act) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && (wa_q[i] == bus.wb_wa)) begin
                    vld_d[i] = 1'b0;
                    n_sq     = n_sq + (PTR_W + 1)'(1);
                end
            end
        end
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + (PTR_W)'(1);
        end
        // Applied after the squash so a same-cycle enqueue survives it.
        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + (PTR_W)'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        sq_sum = {1'b0, sq_q} + 9'(n_sq);
        sq_d   = sq_sum[8] ? 8'hFF : sq_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sq_q     <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                wa_q[i]  <= 5'd0;
                din_q[i] <= 32'd0;
            end
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sq_q     <= sq_d;
            if (push) begin
                wa_q[wr_ptr_q]  <= bus.md_wa;
                din_q[wr_ptr_q] <= bus.md_din;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus a random run, all
// checked against a queue-of-pending-writes model of the arbiter.
module tb_regfile_write_arbiter;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.PTR_W(PTR_W)) bus ();

    regfile_write_arbiter #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] din;
        bit          v;
    } ent_t;

    ent_t        mq[$];
    int          sq_m;
    int          n_vec;
    int          n_err;
    bit          last_tr;
    logic [36:0] wlog[$];
    logic [36:0] exp_q[$];
    logic [81:0] obs_all;

    assign obs_all = {bus.rf_we, bus.rf_wa, bus.rf_din, bus.md_ready,
                      bus.pend_mask, bus.fifo_count, bus.squash_cnt};

    // Expected outputs for the current model contents and current inputs.
    function automatic logic [81:0] model_out();
        logic        we;
        logic [4:0]  wa;
        logic [31:0] din;
        logic [31:0] pm;
        logic        wb_act;
        logic        hv;
        wb_act = bus.wb_we && (bus.wb_wa != 5'd0);
        hv     = (mq.size() > 0) && mq[0].v;
        we  = wb_act || hv;
        wa  = wb_act ? bus.wb_wa  : (hv ? mq[0].wa  : 5'd0);
        din = wb_act ? bus.wb_din : (hv ? mq[0].din : 32'd0);
        pm  = 32'd0;
        for (int i = 0; i < mq.size(); i++) if (mq[i].v) pm[mq[i].wa] = 1'b1;
        pm[0] = 1'b0;
        return {we, wa, din, (mq.size() < DEPTH) ? 1'b1 : 1'b0, pm, 3'(mq.size()), 8'(sq_m)};
    endfunction

    // Logs the write port, then advances model and clock together.
    task automatic tick();
        bit wb_act;
        bit do_pop;
        int k;
        if (bus.rf_we) wlog.push_back({bus.rf_wa, bus.rf_din});
        wb_act  = bus.wb_we && (bus.wb_wa != 5'd0);
        last_tr = bus.md_valid && (mq.size() < DEPTH);
        do_pop  = (mq.size() > 0) && (!mq[0].v || !wb_act);
        @(posedge clk);
        k = 0;
        if (wb_act) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].v && mq[i].wa == bus.wb_wa) begin
                    mq[i].v = 1'b0;
                    k++;
                end
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (last_tr && bus.md_wa != 5'd0) mq.push_back('{wa: bus.md_wa, din: bus.md_din, v: 1'b1});
        sq_m = (sq_m + k > 255) ? 255 : sq_m + k;
        #1;
    endtask

    task automatic drive_idle();
        bus.wb_we    = 1'b0;
        bus.wb_wa    = 5'd0;
        bus.wb_din   = 32'd0;
        bus.md_valid = 1'b0;
        bus.md_wa    = 5'd0;
        bus.md_din   = 32'd0;
    endtask

    task automatic reset_pulse();
        drive_idle();
        #2;
        rst_n = 1'b0;
        mq.delete();
        sq_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        #3;
        n_vec++;
        if ({bus.rf_we, bus.rf_wa, bus.rf_din, bus.md_ready, bus.pend_mask, bus.fifo_count, bus.squash_cnt}
            !== {1'b0, 5'd0, 32'd0, 1'b1, 32'd0, 3'd0, 8'd0}) begin
            n_err++;
            $display("FAIL reset_state: got %h want rf=0 ready=1 mask=0 count=0 sq=0", obs_all);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if (obs_all !== model_out()) begin
                n_err++;
                $display("FAIL reset_idle c%0d: got %h want %h", c, obs_all, model_out());
            end
            tick();
        end
    endtask

    task automatic test_wb_only();
        bus.wb_we = 1'b1; bus.wb_wa = 5'd5; bus.wb_din = 32'hDEADBEEF;
        #1;
        n_vec++;
        if ({bus.rf_we, bus.rf_wa, bus.rf_din} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL wb_write: got we=%b wa=%0d din=%h want 1/5/deadbeef", bus.rf_we, bus.rf_wa, bus.rf_din);
        end
        tick();
        bus.wb_wa = 5'd0;
        #1;
        n_vec++;
        if (bus.rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL wb_null_write: got rf_we=%b want 0", bus.rf_we);
        end
        n_vec++;
        if (obs_all !== model_out()) begin
            n_err++;
            $display("FAIL wb_null_all: got %h want %h", obs_all, model_out());
        end
        tick();
        drive_idle();
    endtask

    task automatic test_md_during_wb();
        for (int c = 0; c < 3; c++) begin
            bus.wb_we = 1'b1; bus.wb_wa = 5'd3; bus.wb_din = $urandom;
            bus.md_valid = (c == 0); bus.md_wa = 5'd8; bus.md_din = 32'h12;
            #1;
            n_vec++;
            if (obs_all !== model_out()) begin
                n_err++;
                $display("FAIL md_burst c%0d: got %h want %h", c, obs_all, model_out());
            end
            if (c > 0) begin
                n_vec++;
                if (bus.pend_mask !== 32'h100) begin
                    n_err++;
                    $display("FAIL md_burst_mask c%0d: got %h want 00000100", c, bus.pend_mask);
                end
            end
            tick();
        end
        drive_idle();
        #1;
        n_vec++;
        if ({bus.rf_we, bus.rf_wa, bus.rf_din} !== {1'b1, 5'd8, 32'h12}) begin
            n_err++;
            $display("FAIL md_drain: got we=%b wa=%0d din=%h want 1/8/12", bus.rf_we, bus.rf_wa, bus.rf_din);
        end
        tick();
        #1;
        n_vec++;
        if ({bus.pend_mask, bus.rf_we} !== {32'd0, 1'b0}) begin
            n_err++;
            $display("FAIL md_after_drain: got mask=%h we=%b want 0/0", bus.pend_mask, bus.rf_we);
        end
        tick();
    endtask

    task automatic test_full();
        int k = 0;
        wlog.delete();
        exp_q.delete();
        for (int j = 0; j < 5; j++) exp_q.push_back({5'(10 + j), 32'h100 + 32'(j)});
        for (int c = 0; c < 20; c++) begin
            bus.wb_we = (c < 8); bus.wb_wa = 5'd1; bus.wb_din = $urandom;
            bus.md_valid = (k < 5); bus.md_wa = 5'(10 + k); bus.md_din = 32'h100 + 32'(k);
            #1;
            n_vec++;
            if (obs_all !== model_out()) begin
                n_err++;
                $display("FAIL full c%0d: got %h want %h", c, obs_all, model_out());
            end
            if (c == 6) begin
                n_vec++;
                if ({bus.md_ready, bus.fifo_count} !== {1'b0, 3'd4}) begin
                    n_err++;
                    $display("FAIL full_state: got ready=%b count=%0d want 0/4", bus.md_ready, bus.fifo_count);
                end
            end
            tick();
            if (last_tr) k++;
        end
        drive_idle();
        for (int i = 0; i < wlog.size(); i++) begin
            if (wlog[i][36:32] == 5'd1) continue;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL full_order: extra write %h", wlog[i]);
            end else if (wlog[i] !== exp_q[0]) begin
                n_err++;
                $display("FAIL full_order: got %h want %h", wlog[i], exp_q[0]);
                void'(exp_q.pop_front());
            end else void'(exp_q.pop_front());
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL full_missing: got %0d writes left undone want 0", exp_q.size());
        end
    endtask

    task automatic test_squash();
        reset_pulse();
        wlog.delete();
        exp_q.delete();
        exp_q.push_back({5'd9, 32'h55});
        exp_q.push_back({5'd10, 32'hBB});
        for (int c = 0; c < 8; c++) begin
            drive_idle();
            if (c < 2) begin
                bus.wb_we = 1'b1; bus.wb_wa = 5'd2; bus.wb_din = $urandom;
                bus.md_valid = 1'b1; bus.md_wa = (c == 0) ? 5'd9 : 5'd10; bus.md_din = (c == 0) ? 32'hAA : 32'hBB;
            end else if (c == 2) begin
                bus.wb_we = 1'b1; bus.wb_wa = 5'd9; bus.wb_din = 32'h55;
            end
            #1;
            n_vec++;
            if (obs_all !== model_out()) begin
                n_err++;
                $display("FAIL squash c%0d: got %h want %h", c, obs_all, model_out());
            end
            if (c == 3) begin
                n_vec++;
                if ({bus.squash_cnt, bus.pend_mask} !== {8'd1, 32'h400}) begin
                    n_err++;
                    $display("FAIL squash_state: got sq=%0d mask=%h want 1/00000400", bus.squash_cnt, bus.pend_mask);
                end
            end
            tick();
        end
        n_vec++;
        for (int i = 0; i < wlog.size(); i++) if (wlog[i][36:32] == 5'd2) wlog.delete(i--);
        if (wlog != exp_q) begin
            n_err++;
            $display("FAIL squash_writes: got %0d writes (first %h) want 2 writes 9=55 then 10=bb",
                     wlog.size(), (wlog.size() > 0) ? wlog[0] : 37'd0);
        end
    endtask

    task automatic test_x0_wrap();
        logic [31:0] din_exp [21];
        int k = 1;
        drive_idle();
        bus.md_valid = 1'b1; bus.md_wa = 5'd0; bus.md_din = $urandom;
        #1;
        tick();
        drive_idle();
        #1;
        n_vec++;
        if ({bus.fifo_count, bus.rf_we, bus.pend_mask} !== {3'd0, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL x0_discard: got count=%0d we=%b mask=%h want 0/0/0", bus.fifo_count, bus.rf_we, bus.pend_mask);
        end
        tick();
        wlog.delete();
        exp_q.delete();
        for (int j = 1; j <= 20; j++) begin
            din_exp[j] = $urandom;
            exp_q.push_back({5'(j), din_exp[j]});
        end
        for (int c = 0; c < 40; c++) begin
            bus.md_valid = (k <= 20);
            bus.md_wa    = (k <= 20) ? 5'(k) : 5'd0;
            bus.md_din   = (k <= 20) ? din_exp[k] : 32'd0;
            #1;
            n_vec++;
            if (obs_all !== model_out()) begin
                n_err++;
                $display("FAIL wrap c%0d: got %h want %h", c, obs_all, model_out());
            end
            tick();
            if (last_tr && k <= 20) k++;
        end
        drive_idle();
        n_vec++;
        if (wlog != exp_q) begin
            n_err++;
            $display("FAIL wrap_order: got %0d writes want 20 to regs 1..20 in order", wlog.size());
        end
    endtask

    task automatic test_random();
        drive_idle();
        last_tr = 1'b1;
        for (int c = 0; c < 400; c++) begin
            bus.wb_we  = ($urandom_range(0, 2) == 0);
            bus.wb_wa  = 5'($urandom_range(0, 7));
            bus.wb_din = $urandom;
            if (!bus.md_valid || last_tr) begin
                bus.md_valid = ($urandom_range(0, 2) != 0);
                bus.md_wa    = 5'($urandom_range(0, 7));
                bus.md_din   = $urandom;
            end
            #1;
            n_vec++;
            if (obs_all !== model_out()) begin
                n_err++;
                $display("FAIL random c%0d: got %h want %h", c, obs_all, model_out());
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            bus.wb_we = 1'b1; bus.wb_wa = 5'd1; bus.wb_din = $urandom;
            bus.md_valid = 1'b1; bus.md_wa = 5'(5 + c); bus.md_din = $urandom;
            #1;
            tick();
        end
        drive_idle();
        #2;
        rst_n = 1'b0;
        mq.delete();
        sq_m = 0;
        #1;
        n_vec++;
        if ({bus.rf_we, bus.rf_wa, bus.rf_din, bus.md_ready, bus.pend_mask, bus.fifo_count, bus.squash_cnt}
            !== {1'b0, 5'd0, 32'd0, 1'b1, 32'd0, 3'd0, 8'd0}) begin
            n_err++;
            $display("FAIL reset_mid: got %h want all zero with ready=1", obs_all);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if (obs_all !== model_out()) begin
                n_err++;
                $display("FAIL reset_no_replay c%0d: got %h want %h", c, obs_all, model_out());
            end
            tick();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        sq_m  = 0;
        last_tr = 1'b0;
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_wb_only();
        test_md_during_wb();
        test_full();
        test_squash();
        test_x0_wrap();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (WE/WA/Din) of the 32x32 register file and shares it between two writers:
  - the pipeline write-back stage, which has absolute priority and no back-pressure;
  - the multi-cycle mul/div unit, which uses a valid/ready handshake.
- Mul/div results go into a DEPTH-entry FIFO and drain into free write-port cycles.
- Exports a per-register pending mask so the hazard unit can stall readers of registers with queued writes.
- Guarantees register 0 is never written.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- PTR_W, 2, log2(DEPTH); set consistently with DEPTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- wb_we  input  1  write-back write request
- wb_wa  input  5  write-back destination register
- wb_din  input  32  write-back data
- md_valid  input  1  mul/div result valid
- md_ready  output  1  arbiter can accept result
- md_wa  input  5  mul/div destination register
- md_din  input  32  mul/div data
- rf_we  output  1  register file write enable
- rf_wa  output  5  register file write address
- rf_din  output  32  register file write data
- pend_mask  output  32  bit i = 1 iff a valid queued entry targets register i
- fifo_count  output  PTR_W+1  occupied entries, valid or squashed
- squash_cnt  output  8  saturating count of squashed entries

Behaviour:
- Reset (async, rst_n = 0):
  - FIFO emptied; all entry valid bits cleared; pointers = 0.
  - fifo_count = 0, squash_cnt = 0, pend_mask = 0, md_ready = 1.
  - rf_we/rf_wa/rf_din = 0 (combinational from cleared state).
  - Reset mid-operation discards queued writes; they are not replayed.
- Write-port selection (combinational, same cycle; the register file captures at the next posedge):
  - Priority 1: wb_we = 1 and wb_wa != 0 -> rf_we = 1, rf_wa = wb_wa, rf_din = wb_din.
  - Priority 2: no WB write and FIFO head valid -> drive head entry; pop at posedge.
  - Otherwise rf_we = 0. rf_wa and rf_din are 0 when rf_we = 0.
  - wb_we = 1 with wb_wa = 0 counts as a null write and leaves the port free.
- Invalid head: popped without any write every cycle, regardless of WB activity.
- Enqueue:
  - md_ready = (fifo_count < DEPTH), derived from registered state only.
  - A transfer occurs when md_valid && md_ready at posedge.
  - md_wa = 0: transfer is accepted and discarded; FIFO unchanged.
  - Enqueue and pop in the same cycle are allowed; count is unchanged.
  - Minimum latency from transfer to rf_we = 1 cycle (no bypass from md_* to rf_*).
- Squash (WAW ordering):
  - At a posedge with wb_we = 1 and wb_wa != 0, every valid FIFO entry with wa == wb_wa is invalidated.
  - squash_cnt += number of entries squashed, saturating at 255.
  - An entry enqueued in that same cycle is not squashed.
- pend_mask:
  - OR over valid entries of the one-hot decode of wa; bit 0 always 0.
  - Updates the cycle after enqueue, pop or squash.
- Full FIFO: md_ready = 0. md_valid with ready low has no effect; the producer must hold md_* until the transfer.
- Pointer wrap: modulo DEPTH; fifo_count distinguishes full from empty.

Test Plan:
- Reset, then idle: rf_we = 0, md_ready = 1, pend_mask = 0, fifo_count = 0; assert rst_n low mid-queue -> all outputs return to 0 immediately, without a clock edge.
- WB only: wb_we = 1, wb_wa = 5, wb_din = 0xDEADBEEF -> same cycle rf_we = 1, rf_wa = 5, rf_din = 0xDEADBEEF; wb_wa = 0 -> rf_we = 0.
- MD during WB burst: md {wa = 8, din = 0x12} transferred while wb_we = 1 for 3 cycles to reg 3 -> pend_mask = 0x100 during the burst; rf writes reg 8 = 0x12 in the first WB-idle cycle; pend_mask = 0 the next cycle.
- Full: hold wb_we = 1 (reg 1); push 5 md results to regs 10..14 -> md_ready = 0 after 4 transfers, fifo_count = 4, 5th held; release WB -> drain order 10, 11, 12, 13, then 14.
- Squash: queue reg 9 (0xAA) and reg 10 (0xBB) under WB to reg 2, then WB writes reg 9 = 0x55 -> squash_cnt = 1, pend_mask = 0x400; only reg 10 = 0xBB is written by drain; reg 9 ends at 0x55.
- x0 and wrap: md to reg 0 -> accepted, fifo_count stays 0, rf_we never asserted; 20 md transfers to regs 1..20 with WB idle -> all written in order, pointers wrap cleanly.
